// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums BURST 17-bit adder results per burst and hands the total downstream
module adder_result_accumulator #(
  parameter int BURST = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      sum,
  input  logic             cout,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [4:0]       count,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state;
  logic [ACC_W-1:0] total;
  logic flag;
  logic [ACC_W:0] next;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign next = {1'b0, total} + (ACC_W+1)'({cout, sum});
  // Burst FSM: accumulate in ACCUM, present the latched total in DONE until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      total <= '0;
      flag <= 1'b0;
      count <= '0;
      acc_out <= '0;
      ovf <= 1'b0;
    end else if (state == DONE) begin
      if (out_ready) begin
        state <= ACCUM;
        acc_out <= '0;
        ovf <= 1'b0;
        count <= '0;
      end
    end else if (clear) begin
      total <= '0;
      flag <= 1'b0;
      count <= '0;
    end else if (in_valid) begin
      if (count == 5'(BURST - 1)) begin
        state <= DONE;
        acc_out <= next[ACC_W-1:0];
        ovf <= flag | next[ACC_W];
        count <= 5'(BURST);
        total <= '0;
        flag <= 1'b0;
      end else begin
        total <= next[ACC_W-1:0];
        flag <= flag | next[ACC_W];
        count <= count + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator: directed scoreboard bench for adder_result_accumulator
module tb_adder_result_accumulator;
  localparam int ACC_W = 17;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sum = '0;
  logic cout = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic clear = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic ovf;
  logic [4:0] count;
  logic out_valid;
  logic out_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  int model_acc = 0;
  int model_cnt = 0;
  logic [17:0] q[$];
  logic [17:0] held;

  adder_result_accumulator #(.BURST(4), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .sum(sum), .cout(cout), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .acc_out(acc_out), .ovf(ovf), .count(count), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    model_acc = 0;
    model_cnt = 0;
  endtask

  task automatic send(input logic [16:0] v);
    in_valid = 1'b1;
    {cout, sum} = v;
    step();
    in_valid = 1'b0;
    model_acc += int'(v);
    model_cnt++;
    if (model_cnt == 4) q.push_back({1'b0, model_acc > 32'h1FFFF, model_acc[16:0]});
    chk("count", 32'(count), 32'(model_cnt));
  endtask

  task automatic check_result();
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    chk("queue", 32'(q.size() != 0), 32'd1);
    held = (q.size() != 0) ? q.pop_front() : '0;
    chk("acc_out", 32'(acc_out), 32'(held[16:0]));
    chk("ovf", 32'(ovf), 32'(held[17]));
    chk("count_done", 32'(count), 32'd4);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_acc_out"}, 32'(acc_out), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check_idle("release");
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    send(17'h0002B);
    send(17'h0002B);
    send(17'h0C7AC);
    send(17'h10000);
    check_result();
    in_valid = 1'b1;
    {cout, sum} = 17'h00055;
    for (int i = 0; i < 5; i++) begin
      clear = (i == 2);
      step();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_acc", 32'(acc_out), 32'h1C802);
      chk("hold_count", 32'(count), 32'd4);
    end
    clear = 1'b0;
    release_out();
    send(17'h00010);
    send(17'h00010);
    clear = 1'b1;
    in_valid = 1'b1;
    {cout, sum} = 17'h00005;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("clear_count", 32'(count), 32'd0);
    step();
    chk("idle_count", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) send(17'h00001);
    check_result();
    release_out();
    for (int i = 0; i < 4; i++) send(17'h1FFFF);
    check_result();
    release_out();
    for (int i = 0; i < 4; i++) send(17'h00001);
    check_result();
    release_out();
    for (int i = 0; i < 3; i++) send(17'h00002);
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check_idle("rst_mid");
    for (int i = 0; i < 4; i++) send(17'h00002);
    check_result();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    model_clear();
    check_idle("rst_done");
    for (int i = 0; i < 4; i++) send(17'h00002);
    check_result();
    release_out();
    send(17'h00007);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_count", 32'(count), 32'd1);
      chk("gap_out_valid", 32'(out_valid), 32'd0);
    end
    send(17'h00007);
    send(17'h00007);
    step();
    chk("gap2_count", 32'(count), 32'd3);
    send(17'h00007);
    check_result();
    release_out();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
